pipe_stage_skid: RTL and testbench

Parametrised elastic pipeline stage register with valid/ready handshake, a 2-entry skid buffer, synchronous flush and bubble zeroing. It is the generic replacement for the fixed MEM/WB-style stage registers. The stage carries any packed payload. Its default payload width matches the writeback bundle {RegWrite, ResultSrc[1:0], ReadData, ALUResult, Rd, PCPlus4} = 104 bits. Upstream stalls come from in_ready; downstream backpressure comes from out_ready.

---
 rtl/pipe_stage_skid.sv | 99 +++++++++
 tb/tb_pipe_stage_skid.sv | 116 +++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic stage register with 2-entry skid buffer, flush and bubble zeroing.
// Optional PIPE_STAGE_STATS_EN adds saturating stall/flush counters.
module pipe_stage_skid #(
    parameter int PAYLOAD_W = 104,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           occ
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t state, state_n;
    logic [PAYLOAD_W-1:0] main_q, main_n, skid_q, skid_n;
    logic in_fire, out_fire;
    assign in_ready    = state != FULL;
    assign out_valid   = state != EMPTY;
    assign out_payload = main_q;
    assign occ         = state;
    assign in_fire     = in_valid & in_ready;
    assign out_fire    = out_valid & out_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_n;
            main_q <= main_n;
            skid_q <= skid_n;
        end
    end
    // main is zeroed whenever the stage drains so bubbles carry no live fields
    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = EMPTY;
            main_n  = '0;
            skid_n  = '0;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    main_n  = in_payload;
                    state_n = ONE;
                end
                ONE: if (in_fire && out_fire) begin
                    main_n = in_payload;
                end else if (in_fire) begin
                    skid_n  = in_payload;
                    state_n = FULL;
                end else if (out_fire) begin
                    main_n  = '0;
                    state_n = EMPTY;
                end
                FULL: if (out_fire) begin
                    main_n  = skid_q;
                    skid_n  = '0;
                    state_n = ONE;
                end
                default: begin
                    main_n  = '0;
                    skid_n  = '0;
                    state_n = EMPTY;
                end
            endcase
        end
    end
`ifdef PIPE_STAGE_STATS_EN
    logic [2:0]     disc;
    logic [CNT_W:0] stall_sum, flush_sum;
    assign disc      = {1'b0, occ} - {2'b0, out_fire} + {2'b0, in_fire};
    assign stall_sum = {1'b0, stall_cnt} + (CNT_W+1)'(1);
    assign flush_sum = {1'b0, flush_cnt} + (CNT_W+1)'(disc);
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready)
                stall_cnt <= stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
            if (flush)
                flush_cnt <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed plus random stimulus checked against a queue-based FIFO model.
module tb_pipe_stage_skid;
    localparam int PW = 104;
    localparam int CW = 32;
    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [PW-1:0] in_payload;
    logic          in_ready, out_valid;
    logic [PW-1:0] out_payload;
    logic [1:0]    occ;
    int            tests = 0, fails = 0;
    logic [PW-1:0] q[$];
`ifdef PIPE_STAGE_STATS_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
    longint        m_stall = 0, m_flush = 0;
`endif

    pipe_stage_skid #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
        .occ(occ)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [PW-1:0] p, input logic ordy);
        int  n;
        bit  ifire, ofire;
        rst = r; flush = f; in_valid = iv; in_payload = p; out_ready = ordy;
        @(negedge clk);
        n = q.size();
        chk("out_valid", PW'(out_valid), PW'(n != 0));
        chk("in_ready", PW'(in_ready), PW'(n < 2));
        chk("occ", PW'(occ), PW'(n));
        chk("out_payload", out_payload, n != 0 ? q[0] : '0);
`ifdef PIPE_STAGE_STATS_EN
        chk("stall_cnt", PW'(stall_cnt), PW'(m_stall));
        chk("flush_cnt", PW'(flush_cnt), PW'(m_flush));
`endif
        ifire = iv && n < 2;
        ofire = n != 0 && ordy;
        if (r) begin
            q.delete();
`ifdef PIPE_STAGE_STATS_EN
            m_stall = 0; m_flush = 0;
`endif
        end else begin
`ifdef PIPE_STAGE_STATS_EN
            if (n != 0 && !ordy) m_stall++;
            if (f) m_flush += n - int'(ofire) + int'(ifire);
`endif
            if (f) q.delete();
            else begin
                if (ofire) void'(q.pop_front());
                if (ifire) q.push_back(p);
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] rnd();
        return PW'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_payload = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(0, 0, 0, '0, 0);
        step(0, 0, 0, '0, 1);
        for (int i = 1; i <= 8; i++) step(0, 0, 1, PW'(i), 1);
        step(0, 0, 0, '0, 1);
        step(0, 0, 1, PW'('hA), 0);
        step(0, 0, 1, PW'('hB), 0);
        step(0, 0, 1, PW'('hD), 0);
        step(0, 0, 0, '0, 0);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 1);
        step(0, 0, 1, PW'('h5), 0);
        step(0, 0, 1, PW'('h6), 1);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 1);
        step(0, 0, 1, PW'('hA), 0);
        step(0, 0, 1, PW'('hB), 0);
        step(0, 1, 1, PW'('hC), 0);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 1);
        step(0, 0, 1, PW'('h11), 0);
        step(0, 0, 1, PW'('h12), 0);
        step(1, 0, 1, PW'('h13), 1);
        step(0, 0, 0, '0, 1);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 2) != 0);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
